// File: rtl/match_score_timer.sv
`default_nettype none
// ============================================================================
// match_score_timer : player scores, mm:ss match countdown and post-point
//                     serve hold; freezes on win score or 0:00.
// Revision: 1.0
// ============================================================================
module match_score_timer #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int START_MIN     = 2,
  parameter int START_SEC     = 0,
  parameter int WIN_SCORE     = 6,
  parameter int SERVE_CYCLES  = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_active,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [3:0] scoreP1,
  output logic [3:0] scoreP2,
  output logic [5:0] timer_minutes,
  output logic [5:0] timer_seconds,
  output logic       serve_hold,
  output logic       sec_tick,
  output logic       match_done
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int HW = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;

  localparam logic [PW-1:0] C_PRE_LAST  = PW'(TICKS_PER_SEC - 1);
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(SERVE_CYCLES - 1);
  localparam logic [3:0]    C_WIN       = 4'(WIN_SCORE);
  localparam logic [5:0]    C_START_MIN = 6'(START_MIN);
  localparam logic [5:0]    C_START_SEC = 6'(START_SEC);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HOLD     = 2'd1,
    ST_FINISHED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]    s1_q, s1_d, s2_q, s2_d;
  logic [5:0]    min_q, min_d, sec_q, sec_d;
  logic          p1_prev_q, p2_prev_q;
  logic          serve_hold_q, sec_tick_q, match_done_q;

  logic          w_edge1, w_edge2, w_pre_run, w_tick, w_counted, w_win, w_time_zero;

  always_comb begin
    w_edge1    = point_p1 & ~p1_prev_q;
    w_edge2    = point_p2 & ~p2_prev_q;
    w_pre_run  = game_active && (state_q != ST_FINISHED);
    w_tick     = w_pre_run && (pre_q == C_PRE_LAST);

    pre_d = pre_q;
    if (w_pre_run) begin
      pre_d = w_tick ? '0 : pre_q + 1'b1;
    end

    min_d = min_q;
    sec_d = sec_q;
    if (w_tick) begin
      if (sec_q != 6'd0) begin
        sec_d = sec_q - 6'd1;
      end else if (min_q != 6'd0) begin
        min_d = min_q - 6'd1;
        sec_d = 6'd59;
      end
    end
    w_time_zero = w_tick && (min_d == 6'd0) && (sec_d == 6'd0);

    // Simultaneous edges from both players cancel out entirely
    w_counted = (state_q == ST_RUN) && game_active && (w_edge1 ^ w_edge2);
    s1_d      = s1_q + 4'(w_counted && w_edge1);
    s2_d      = s2_q + 4'(w_counted && w_edge2);
    w_win     = w_counted && ((s1_d == C_WIN) || (s2_d == C_WIN));

    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if ((state_q == ST_HOLD) && game_active) begin
      if (hold_cnt_q == C_HOLD_LAST) begin
        state_d = ST_RUN;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
    if (w_counted) begin
      state_d    = ST_HOLD;
      hold_cnt_d = '0;
    end
    if (w_win || w_time_zero) begin
      state_d = ST_FINISHED;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pre_q        <= '0;
      hold_cnt_q   <= '0;
      s1_q         <= 4'd0;
      s2_q         <= 4'd0;
      min_q        <= C_START_MIN;
      sec_q        <= C_START_SEC;
      p1_prev_q    <= 1'b0;
      p2_prev_q    <= 1'b0;
      serve_hold_q <= 1'b0;
      sec_tick_q   <= 1'b0;
      match_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      hold_cnt_q   <= hold_cnt_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      p1_prev_q    <= point_p1;
      p2_prev_q    <= point_p2;
      serve_hold_q <= (state_d == ST_HOLD);
      sec_tick_q   <= w_tick;
      match_done_q <= (state_d == ST_FINISHED);
    end
  end

  assign scoreP1       = s1_q;
  assign scoreP2       = s2_q;
  assign timer_minutes = min_q;
  assign timer_seconds = sec_q;
  assign serve_hold    = serve_hold_q;
  assign sec_tick      = sec_tick_q;
  assign match_done    = match_done_q;

endmodule
`default_nettype wire
